// File: rtl/booth_mult_serial.sv
// Sequential radix-2 Booth multiplier (one step per clock) with an optional LSB-first serial framer.
// Define BOOTH_MULT_SERIAL_TX_EN to compile in the TX framer; otherwise tx is tied high.
module booth_mult_serial #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 tx
);

    localparam int unsigned CntW = $clog2(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("booth_mult_serial: WIDTH must be at least 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("booth_mult_serial: CLKS_PER_BIT must be at least 1");
    end

`ifdef BOOTH_MULT_SERIAL_TX_EN
    typedef enum logic [1:0] {StIdle, StCalc, StTx} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCalc} state_e;
`endif

    state_e state_q, state_d;

    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic               qm_q, qm_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH+1:0] shifted;
    logic               last_step;

`ifdef BOOTH_MULT_SERIAL_TX_EN
    localparam int unsigned BitW  = $clog2(2 * WIDTH + 2);
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic               tx_q, tx_d;
    logic [2*WIDTH:0]   sh_q, sh_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic               bit_last, baud_last;

    assign bit_last  = (bit_q == BitW'(2 * WIDTH + 1));
    assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));
`endif

    assign last_step = (cnt_q == CntW'(WIDTH - 1));

    // Booth add/subtract followed by an arithmetic right shift of {acc, Q, q_minus}.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm_q})
            2'b10:   step_sum = acc_q - m_ext;
            2'b01:   step_sum = acc_q + m_ext;
            default: step_sum = acc_q;
        endcase
        shifted = {step_sum[WIDTH], step_sum, q_q};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            qm_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef BOOTH_MULT_SERIAL_TX_EN
            tx_q      <= 1'b1;
            sh_q      <= '0;
            bit_q     <= '0;
            baud_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            qm_q      <= qm_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef BOOTH_MULT_SERIAL_TX_EN
            tx_q      <= tx_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            baud_q    <= baud_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StCalc;
            StCalc: begin
                if (last_step) begin
`ifdef BOOTH_MULT_SERIAL_TX_EN
                    state_d = StTx;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef BOOTH_MULT_SERIAL_TX_EN
            StTx: if (bit_last && baud_last) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        qm_d      = qm_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
`ifdef BOOTH_MULT_SERIAL_TX_EN
        tx_d      = tx_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        baud_d    = baud_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    m_d    = multiplicand;
                    q_d    = multiplier;
                    acc_d  = '0;
                    qm_d   = 1'b0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            StCalc: begin
                acc_d = shifted[2*WIDTH+1:WIDTH+1];
                q_d   = shifted[WIDTH:1];
                qm_d  = shifted[0];
                cnt_d = cnt_q + CntW'(1);
                if (last_step) begin
                    product_d = shifted[2*WIDTH:1];
                    done_d    = 1'b1;
`ifdef BOOTH_MULT_SERIAL_TX_EN
                    // Start bit goes out in the done cycle; stop bit rides at the top of sh.
                    tx_d   = 1'b0;
                    sh_d   = {1'b1, shifted[2*WIDTH:1]};
                    bit_d  = '0;
                    baud_d = '0;
`else
                    busy_d = 1'b0;
`endif
                end
            end
`ifdef BOOTH_MULT_SERIAL_TX_EN
            StTx: begin
                if (baud_last) begin
                    baud_d = '0;
                    bit_d  = bit_q + BitW'(1);
                    tx_d   = sh_q[0];
                    sh_d   = {1'b1, sh_q[2*WIDTH:1]};
                    if (bit_last) begin
                        tx_d   = 1'b1;
                        busy_d = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`endif
            default: ;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
`ifdef BOOTH_MULT_SERIAL_TX_EN
    assign tx      = tx_q;
`else
    assign tx      = 1'b1;
`endif

endmodule

// File: doc/booth_mult_serial.md
# booth_mult_serial

Parametrised sequential radix-2 Booth multiplier with a built-in serial result transmitter. It is the successor to the team's fixed 4-bit combinational Booth multiplier. It adds a configurable operand width and a start/busy/done handshake, performs one Booth step per clock, and produces an exact 2·WIDTH-bit product with no overflow at the most-negative operands. The serial output frames each product for the board's single-wire link at a configurable bit period.

## Interface
- WIDTH, 8: operand width in bits, ≥ 2; product is 2·WIDTH bits.
- CLKS_PER_BIT, 1: CLK cycles per serial bit, ≥ 1.

Ports (one clock, CLK; reset is synchronous and active-high, RST):
- CLK  in  1  global clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy = 0.
- multiplier  in  WIDTH  signed operand Q; sampled on the accepted start.
- multiplicand  in  WIDTH  signed operand M; sampled on the accepted start.
- busy  out  1  high from the accepted start until the job finishes.
- done  out  1  one-cycle pulse; product is valid from this cycle on.
- product  out  2·WIDTH  signed result; holds its value until the next done.
- tx  out  1  serial frame output; idle level is 1.

## Operation
- States: IDLE, CALC, TX (TX exists only with the macro; see Configuration).
- IDLE, start = 1 at an edge: the job is accepted.
  - Latch M and Q. Clear acc (WIDTH+1 bits) and q_minus. Clear step count.
  - busy goes to 1. State moves to CALC.
- CALC: one Booth step per edge, WIDTH steps in total.
  - {Q[0], q_minus} = 10: acc ← acc − sext(M).
  - {Q[0], q_minus} = 01: acc ← acc + sext(M).
  - 00 or 11: acc is unchanged.
  - Then arithmetic-shift {acc, Q, q_minus} right by 1.
  - acc is WIDTH+1 bits, so −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2·WIDTH−2) is exact.
  - product = {acc[WIDTH−1:0], Q} after the final step.
- Final step edge: write product and assert done for one cycle. Then:
  - Macro defined: state moves to TX.
  - Macro undefined: state moves to IDLE.
- TX frame, each bit held CLKS_PER_BIT cycles:
  - Start bit 0.
  - product[0] … product[2·WIDTH−1], LSB first.
  - Stop bit 1.
  - Then state moves to IDLE, busy goes to 0, tx stays 1.
- start while busy = 1 is ignored. A held start launches a new job only once the block is back in IDLE.
- Operands are only sampled on acceptance. Changes during CALC or TX have no effect.
- Reset, at any time including mid-CALC or mid-TX:
  - Next edge: state IDLE, busy 0, done 0, product 0, tx 1.
  - Any partial frame is abandoned.

## Timing
- Start accepted at edge E0. Booth steps happen at edges E1..E_WIDTH.
- done and the new product are visible in the cycle after E_WIDTH, i.e. WIDTH+1 edges after the cycle in which start was high.
- Macro defined:
  - The start bit is driven on tx from edge E_WIDTH, the same cycle done is high.
  - The frame lasts (2·WIDTH+2)·CLKS_PER_BIT cycles.
  - busy falls at the edge that ends the stop bit.
  - Minimum start-to-start spacing: WIDTH+1+(2·WIDTH+2)·CLKS_PER_BIT cycles.
- Macro undefined:
  - busy falls at E_WIDTH, so it is already 0 in the done cycle.
  - start may be accepted in that same done cycle.
  - Spacing: WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- BOOTH_MULT_SERIAL_TX_EN:
  - Defined: the TX state, bit counter and baud counter are compiled in, and framing behaves as above.
  - Undefined: TX logic is absent, tx is tied to 1, and the block is a pure handshake multiplier. CLKS_PER_BIT is accepted but unused.

## Test plan
- WIDTH=8, macro undefined. Start with Q=7, M=−3 → done 9 edges after start, product=0xFFEB (−21), busy low in the done cycle.
- WIDTH=8. Q=−128, M=−128 → product=0x4000. Also Q=−128, M=127 → 0xC080. Also Q=0, M=−5 → 0x0000.
- WIDTH=8, CLKS_PER_BIT=2, macro defined. Product 0x4000 → tx is idle 1, then 0 for 2 cycles, then bits 0…15 each for 2 cycles (only bit 14 = 1), then 1 for 2 cycles. busy falls 36 cycles after done.
- Pulse start with new operands during CALC and during TX → ignored; product and frame are unchanged. A start held high launches a second job right after busy falls.
- Assert RST in the middle of the data bits → next edge tx=1, busy=0, done=0, product=0. A subsequent start with Q=3, M=5 yields product=15.
- WIDTH=4, macro defined. Q=−8, M=−8 → product=0x40, done after 5 edges. 10-bit frame with CLKS_PER_BIT=1 reads 0, 0,0,0,0,0,0,1,0, 1.
